// File: rtl/keypad_entry_controller.sv
// Keypad operand-entry controller: builds two 3-digit BCD operands plus an operator and hands them to an arithmetic unit.
// Optional inactivity auto-clear is enabled by defining ENTRY_TIMEOUT_EN.
module keypad_entry_controller #(
  parameter int RELEASE_CYCLES = 16384,
  parameter int TIMEOUT_CYCLES = 27000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key,
  input  logic        key_pressed,
  input  logic        calc_ack,
  output logic [11:0] op_a,
  output logic [11:0] op_b,
  output logic [1:0]  op_code,
  output logic        calc_req,
  output logic [11:0] disp_val,
  output logic [1:0]  entry_state,
  output logic        err,
  output logic        timeout
);

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    REQUEST = 2'b10
  } state_t;

  localparam int GW = $clog2(RELEASE_CYCLES);

  state_t         state;
  logic [1:0]     count;
  logic [3:0]     last_key;
  logic           released;
  logic [GW-1:0]  gap;
  logic           done;
  logic           accept;
  logic           is_digit;
  logic           is_op;
  logic           fire;

  assign accept      = key_pressed && (key != 4'hE) && (released || (key != last_key));
  assign is_digit    = (key <= 4'd9);
  assign is_op       = (key >= 4'hA) && (key <= 4'hC);
  assign disp_val    = (state == ENTER_B) ? op_b : op_a;
  assign entry_state = state;

  // A held key keeps pulsing; it only counts as released after a long enough gap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gap      <= '0;
      released <= 1'b1;
      last_key <= '0;
    end else if (key_pressed) begin
      gap <= '0;
      if (accept) begin
        last_key <= key;
        released <= 1'b0;
      end
    end else if (gap == GW'(RELEASE_CYCLES - 1)) begin
      released <= 1'b1;
    end else begin
      gap <= gap + GW'(1);
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] idle_cnt;
  logic          active;

  assign active = (state == ENTER_B) || ((state == ENTER_A) && (count != 2'd0));
  assign fire   = active && !accept && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= fire;
      if (!active || accept || fire) idle_cnt <= '0;
      else                           idle_cnt <= idle_cnt + TW'(1);
    end
  end
`else
  assign fire    = 1'b0;
  assign timeout = 1'b0;
`endif

  // done marks a finished calculation whose results stay on display until new entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ENTER_A;
      op_a     <= '0;
      op_b     <= '0;
      op_code  <= '0;
      calc_req <= 1'b0;
      err      <= 1'b0;
      count    <= '0;
      done     <= 1'b0;
    end else begin
      err <= 1'b0;
      if (state == REQUEST) begin
        if (calc_ack) begin
          calc_req <= 1'b0;
          state    <= ENTER_A;
          count    <= '0;
          done     <= 1'b1;
        end
      end else if (accept) begin
        if (is_digit) begin
          if (count == 2'd3) begin
            err <= 1'b1;
          end else begin
            count <= count + 2'd1;
            if (state == ENTER_B) begin
              op_b <= {op_b[7:0], key};
            end else if (done) begin
              op_a <= {8'h00, key};
              op_b <= '0;
              done <= 1'b0;
            end else begin
              op_a <= {op_a[7:0], key};
            end
          end
        end else if (is_op) begin
          if ((state == ENTER_A) && (count != 2'd0)) begin
            op_code <= key[1:0] - 2'd2;
            state   <= ENTER_B;
            count   <= '0;
            op_b    <= '0;
          end else if ((state == ENTER_B) && (count == 2'd0)) begin
            op_code <= key[1:0] - 2'd2;
          end else begin
            err <= 1'b1;
          end
        end else if (key == 4'hF) begin
          if ((state == ENTER_B) && (count != 2'd0)) begin
            state    <= REQUEST;
            calc_req <= 1'b1;
          end else begin
            err <= 1'b1;
          end
        end else begin
          op_a    <= '0;
          op_b    <= '0;
          op_code <= '0;
          count   <= '0;
          state   <= ENTER_A;
          done    <= 1'b0;
        end
      end else if (fire) begin
        op_a    <= '0;
        op_b    <= '0;
        op_code <= '0;
        count   <= '0;
        state   <= ENTER_A;
        done    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Self-checking bench for keypad_entry_controller: table vectors, directed corner sequences and
// randomized traffic against a decimal-arithmetic reference model.
module tb_keypad_entry_controller;

  localparam int RC = 8;
  localparam int TC = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  key = 4'h0;
  logic        key_pressed = 1'b0;
  logic        calc_ack = 1'b0;
  logic [11:0] op_a, op_b, disp_val;
  logic [1:0]  op_code, entry_state;
  logic        calc_req, err, timeout;

  int vectors = 0;
  int miscompares = 0;

  keypad_entry_controller #(.RELEASE_CYCLES(RC), .TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .rst(rst), .key(key), .key_pressed(key_pressed), .calc_ack(calc_ack),
    .op_a(op_a), .op_b(op_b), .op_code(op_code), .calc_req(calc_req),
    .disp_val(disp_val), .entry_state(entry_state), .err(err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: operands held as decimal integers, mode 0/1/2 = entering A / entering B / waiting.
  int         m_mode, m_a, m_b, m_cnt, m_op, m_idle, m_inact;
  bit         m_req, m_err, m_done, m_rel, m_to;
  logic [3:0] m_last;

  function automatic logic [11:0] bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic modelReset();
    m_mode = 0; m_a = 0; m_b = 0; m_cnt = 0; m_op = 0; m_idle = 0; m_inact = 0;
    m_req = 0; m_err = 0; m_done = 0; m_rel = 1; m_to = 0; m_last = 4'h0;
  endtask

  task automatic modelClear();
    m_a = 0; m_b = 0; m_op = 0; m_cnt = 0; m_mode = 0; m_done = 0;
  endtask

  task automatic modelStep(input logic kp, input logic [3:0] k, input logic ack);
    bit acc;
    bit active;
    acc    = kp && (k != 4'hE) && (m_rel || (k != m_last));
    active = (m_mode == 1) || (m_mode == 0 && m_cnt > 0);
    m_err  = 0;
    m_to   = 0;
    if (kp) begin
      m_idle = 0;
      if (acc) begin
        m_last = k;
        m_rel  = 0;
      end
    end else begin
      m_idle++;
      if (m_idle >= RC) m_rel = 1;
    end
    if (m_mode == 2) begin
      if (ack) begin
        m_req = 0; m_mode = 0; m_cnt = 0; m_done = 1;
      end
    end else if (acc) begin
      if (k <= 4'd9) begin
        if (m_cnt == 3) m_err = 1;
        else begin
          if (m_mode == 1) m_b = m_b * 10 + int'(k);
          else begin
            if (m_done) begin m_a = 0; m_b = 0; m_done = 0; end
            m_a = m_a * 10 + int'(k);
          end
          m_cnt++;
        end
      end else if (k >= 4'hA && k <= 4'hC) begin
        if (m_mode == 0 && m_cnt >= 1) begin
          m_op = int'(k) - 10; m_mode = 1; m_cnt = 0; m_b = 0;
        end else if (m_mode == 1 && m_cnt == 0) m_op = int'(k) - 10;
        else m_err = 1;
      end else if (k == 4'hF) begin
        if (m_mode == 1 && m_cnt >= 1) begin m_mode = 2; m_req = 1; end
        else m_err = 1;
      end else begin
        modelClear();
      end
    end
`ifdef ENTRY_TIMEOUT_EN
    if (active && !acc) begin
      m_inact++;
      if (m_inact == TC) begin
        modelClear();
        m_to = 1;
        m_inact = 0;
      end
    end else begin
      m_inact = 0;
    end
`else
    if (active) m_inact = 0;
`endif
  endtask

  // One clock cycle: drive at a falling edge, let the rising edge act, return at the next falling edge.
  task automatic applyStimulus(input logic kp, input logic [3:0] k, input logic ack);
    key_pressed = kp;
    key         = k;
    calc_ack    = ack;
    if (!rst) modelReset();
    else      modelStep(kp, k, ack);
    @(negedge clk);
  endtask

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name);
    logic [11:0] exp_disp;
    exp_disp = (m_mode == 1) ? bcd(m_b) : bcd(m_a);
    checkValue(name,
      {21'd0, op_a, op_b, op_code, calc_req, disp_val, entry_state, err, timeout},
      {21'd0, bcd(m_a), bcd(m_b), 2'(m_op), m_req, exp_disp, 2'(m_mode), m_err, m_to});
  endtask

  task automatic idleCycles(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 4'h0, 1'b0);
      checkOutput(name);
    end
  endtask

  task automatic pressKey(input logic [3:0] k, input int idle, input string name);
    applyStimulus(1'b1, k, 1'b0);
    checkOutput(name);
    idleCycles(idle, name);
  endtask

  typedef struct {
    logic [3:0]  k;
    int          idle;
    logic [11:0] a;
    logic [11:0] b;
    logic [1:0]  code;
    logic [1:0]  st;
    logic        req;
    logic        er;
  } vec_t;

  vec_t tbl[15];
  int   to_pulses;

  initial begin
    tbl[0]  = '{4'hE, 10, 12'h000, 12'h000, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{4'h9, 10, 12'h009, 12'h000, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{4'h8, 10, 12'h098, 12'h000, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[3]  = '{4'h7, 10, 12'h987, 12'h000, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[4]  = '{4'h6, 10, 12'h987, 12'h000, 2'b00, 2'b00, 1'b0, 1'b1};
    tbl[5]  = '{4'hF, 10, 12'h987, 12'h000, 2'b00, 2'b00, 1'b0, 1'b1};
    tbl[6]  = '{4'hD, 10, 12'h000, 12'h000, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[7]  = '{4'hA, 10, 12'h000, 12'h000, 2'b00, 2'b00, 1'b0, 1'b1};
    tbl[8]  = '{4'h1, 10, 12'h001, 12'h000, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[9]  = '{4'h2, 10, 12'h012, 12'h000, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[10] = '{4'hB, 10, 12'h012, 12'h000, 2'b01, 2'b01, 1'b0, 1'b0};
    tbl[11] = '{4'hA, 10, 12'h012, 12'h000, 2'b00, 2'b01, 1'b0, 1'b0};
    tbl[12] = '{4'h3, 10, 12'h012, 12'h003, 2'b00, 2'b01, 1'b0, 1'b0};
    tbl[13] = '{4'hC, 10, 12'h012, 12'h003, 2'b00, 2'b01, 1'b0, 1'b1};
    tbl[14] = '{4'hF,  3, 12'h012, 12'h003, 2'b00, 2'b10, 1'b1, 1'b0};

    modelReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 4'h0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkValue("reset_state", {op_a, op_b, op_code, calc_req, entry_state, err, timeout}, '0);
    rst = 1'b1;
    idleCycles(2, "post_reset");

    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, tbl[i].k, 1'b0);
      checkValue($sformatf("table_%0d", i),
        {op_a, op_b, op_code, entry_state, calc_req, err},
        {tbl[i].a, tbl[i].b, tbl[i].code, tbl[i].st, tbl[i].req, tbl[i].er});
      checkOutput($sformatf("table_%0d_model", i));
      idleCycles(tbl[i].idle, "table_idle");
    end

    applyStimulus(1'b0, 4'h0, 1'b1);
    checkValue("ack_result", {op_a, op_b, op_code, calc_req, entry_state},
               {12'h012, 12'h003, 2'b00, 1'b0, 2'b00});
    checkOutput("ack_model");
    idleCycles(10, "ack_idle");

    pressKey(4'h1, 10, "req031_1");
    checkValue("fresh_entry_clears", {op_a, op_b}, {12'h001, 12'h000});
    pressKey(4'hC, 10, "req031_c");
    checkValue("op_multiply", {op_code, entry_state}, {2'b10, 2'b01});
    pressKey(4'h2, 10, "req031_2");
    pressKey(4'hF, 2, "req031_f");
    applyStimulus(1'b1, 4'h4, 1'b1);
    checkValue("ack_beats_key", {op_a, entry_state, err, calc_req}, {12'h001, 2'b00, 1'b0, 1'b0});
    checkOutput("ack_beats_key_model");
    idleCycles(10, "req031_idle");
    pressKey(4'h4, 0, "req031_4");
    checkValue("key_after_ack", {op_a, op_b}, {12'h004, 12'h000});
    idleCycles(10, "req031_idle2");

    pressKey(4'hD, 10, "req029_clr");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(i % 6 == 0, 4'h5, 1'b0);
      checkOutput("held_key");
    end
    checkValue("held_key_once", {20'd0, op_a}, {20'd0, 12'h005});
    idleCycles(10, "held_release");
    pressKey(4'h5, 0, "req029_5");
    checkValue("repeat_after_release", {20'd0, op_a}, {20'd0, 12'h055});
    idleCycles(10, "req029_idle");

    pressKey(4'hD, 10, "req032_clr");
    pressKey(4'h7, 0, "req032_7");
    to_pulses = 0;
    for (int i = 0; i < TC; i++) begin
      applyStimulus(1'b0, 4'h0, 1'b0);
      checkOutput("inactivity");
      if (timeout) to_pulses++;
    end
`ifdef ENTRY_TIMEOUT_EN
    checkValue("timeout_fires", {op_a, 32'(to_pulses)}, {12'h000, 32'd1});
`else
    checkValue("no_timeout", {op_a, 32'(to_pulses)}, {12'h007, 32'd0});
`endif

    pressKey(4'hD, 10, "req033_clr");
    pressKey(4'h1, 10, "req033_1");
    pressKey(4'hA, 10, "req033_a");
    pressKey(4'h2, 10, "req033_2");
    pressKey(4'hF, 1, "req033_f");
    checkValue("req_pending", {31'd0, calc_req}, {31'd0, 1'b1});
    rst = 1'b0;
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkValue("reset_over_req",
      {op_a, op_b, op_code, calc_req, disp_val, entry_state, err, timeout}, '0);
    rst = 1'b1;
    idleCycles(3, "post_reset2");

    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 499) != 0);
      applyStimulus($urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
      checkOutput("random");
    end
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
